// File: rtl/rx_cmd_pkg.sv
// rtl/rx_cmd_pkg.sv - shared command codes, state encoding and ALU operand addresses
package rx_cmd_pkg;

  localparam logic [7:0] CMD_WR     = 8'hAA;
  localparam logic [7:0] CMD_RD     = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP = 8'hCC;
  localparam logic [7:0] CMD_ALU    = 8'hDD;

  // Register-file slots that receive the ALU operands of a 0xCC frame
  localparam int OP_A_ADDR = 0;
  localparam int OP_B_ADDR = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    OP_A    = 3'd4,
    OP_B    = 3'd5,
    ALU_FUN = 3'd6
  } state_t;

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - inter-byte idle counter that flags an abandoned frame
module frame_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Count consecutive enabled cycles without a clear
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Fires in the cycle that would bring the count to TIMEOUT; a clear in that cycle wins
  always_comb begin
    expired = enable && !clear && (r_cnt == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/rx_cmd_decoder.sv
// rtl/rx_cmd_decoder.sv - byte-stream command decoder driving register-file and ALU strobes
module rx_cmd_decoder
  import rx_cmd_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  rx_data,
  input  logic              rx_valid,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [WIDTH-1:0]  rf_wr_data,
  output logic              alu_en,
  output logic [3:0]        alu_fun,
  output logic              frame_err,
  output logic              busy
);

  state_t              r_state;
  state_t              w_next_state;

  logic                r_wr_en;
  logic                r_rd_en;
  logic                r_alu_en;
  logic                r_frame_err;
  logic [ADDR_W-1:0]   r_rf_addr;
  logic [WIDTH-1:0]    r_rf_wr_data;
  logic [3:0]          r_alu_fun;
  logic [ADDR_W-1:0]   r_lat_addr;

  logic                w_nxt_wr_en;
  logic                w_nxt_rd_en;
  logic                w_nxt_alu_en;
  logic                w_nxt_frame_err;
  logic [ADDR_W-1:0]   w_nxt_rf_addr;
  logic [WIDTH-1:0]    w_nxt_rf_wr_data;
  logic [3:0]          w_nxt_alu_fun;
  logic [ADDR_W-1:0]   w_nxt_lat_addr;

  logic                w_busy;
  logic                w_timer_clear;
  logic                w_expired;

  assign w_busy        = (r_state != IDLE);
  assign w_timer_clear = rx_valid || (r_state == IDLE);

  frame_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_frame_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_timer_clear),
    .enable  (w_busy),
    .expired (w_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and next output values; a received byte always takes priority over timeout
  always_comb begin
    w_next_state     = r_state;
    w_nxt_wr_en      = 1'b0;
    w_nxt_rd_en      = 1'b0;
    w_nxt_alu_en     = 1'b0;
    w_nxt_frame_err  = 1'b0;
    w_nxt_rf_addr    = r_rf_addr;
    w_nxt_rf_wr_data = r_rf_wr_data;
    w_nxt_alu_fun    = r_alu_fun;
    w_nxt_lat_addr   = r_lat_addr;
    if (rx_valid) begin
      case (r_state)
        IDLE: begin
          if (rx_data == WIDTH'(CMD_WR)) begin
            w_next_state = WR_ADDR;
          end else if (rx_data == WIDTH'(CMD_RD)) begin
            w_next_state = RD_ADDR;
          end else if (rx_data == WIDTH'(CMD_ALU_OP)) begin
            w_next_state = OP_A;
          end else if (rx_data == WIDTH'(CMD_ALU)) begin
            w_next_state = ALU_FUN;
          end else begin
            w_nxt_frame_err = 1'b1;
          end
        end
        WR_ADDR: begin
          w_nxt_lat_addr = rx_data[ADDR_W-1:0];
          w_next_state   = WR_DATA;
        end
        WR_DATA: begin
          w_nxt_wr_en      = 1'b1;
          w_nxt_rf_addr    = r_lat_addr;
          w_nxt_rf_wr_data = rx_data;
          w_next_state     = IDLE;
        end
        RD_ADDR: begin
          w_nxt_rd_en   = 1'b1;
          w_nxt_rf_addr = rx_data[ADDR_W-1:0];
          w_next_state  = IDLE;
        end
        OP_A: begin
          w_nxt_wr_en      = 1'b1;
          w_nxt_rf_addr    = ADDR_W'(OP_A_ADDR);
          w_nxt_rf_wr_data = rx_data;
          w_next_state     = OP_B;
        end
        OP_B: begin
          w_nxt_wr_en      = 1'b1;
          w_nxt_rf_addr    = ADDR_W'(OP_B_ADDR);
          w_nxt_rf_wr_data = rx_data;
          w_next_state     = ALU_FUN;
        end
        ALU_FUN: begin
          w_nxt_alu_en  = 1'b1;
          w_nxt_alu_fun = rx_data[3:0];
          w_next_state  = IDLE;
        end
        default: begin
          w_next_state = IDLE;
        end
      endcase
    end else if (w_expired) begin
      w_nxt_frame_err = 1'b1;
      w_next_state    = IDLE;
    end
  end

  // Registered strobes and held data outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_alu_en     <= 1'b0;
      r_frame_err  <= 1'b0;
      r_rf_addr    <= '0;
      r_rf_wr_data <= '0;
      r_alu_fun    <= '0;
      r_lat_addr   <= '0;
    end else begin
      r_wr_en      <= w_nxt_wr_en;
      r_rd_en      <= w_nxt_rd_en;
      r_alu_en     <= w_nxt_alu_en;
      r_frame_err  <= w_nxt_frame_err;
      r_rf_addr    <= w_nxt_rf_addr;
      r_rf_wr_data <= w_nxt_rf_wr_data;
      r_alu_fun    <= w_nxt_alu_fun;
      r_lat_addr   <= w_nxt_lat_addr;
    end
  end

  assign rf_wr_en   = r_wr_en;
  assign rf_rd_en   = r_rd_en;
  assign rf_addr    = r_rf_addr;
  assign rf_wr_data = r_rf_wr_data;
  assign alu_en     = r_alu_en;
  assign alu_fun    = r_alu_fun;
  assign frame_err  = r_frame_err;
  assign busy       = w_busy;

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// tb/tb_rx_cmd_decoder.sv - self-checking bench for rx_cmd_decoder against a frame-level model
module tb_rx_cmd_decoder;

  localparam int WIDTH   = 8;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rf_wr_en;
  logic       rf_rd_en;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic       alu_en;
  logic [3:0] alu_fun;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  rx_cmd_decoder #(
    .WIDTH   (WIDTH),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rf_wr_en   (rf_wr_en),
    .rf_rd_en   (rf_rd_en),
    .rf_addr    (rf_addr),
    .rf_wr_data (rf_wr_data),
    .alu_en     (alu_en),
    .alu_fun    (alu_fun),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Frame-level model: collects the bytes of the open frame and acts on byte position
  logic [7:0] frame[$];
  int         idle_cnt = 0;
  int         pos;
  bit         done;
  logic [7:0] addr_byte;
  logic       e_wr = 0, e_rd = 0, e_alu = 0, e_err = 0, e_busy = 0;
  logic [3:0] e_addr = 0, e_fun = 0;
  logic [7:0] e_data = 0;

  function automatic bit is_cmd(logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hBB) || (b == 8'hCC) || (b == 8'hDD);
  endfunction

  always @(posedge clk) begin
    e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0;
    if (rst) begin
      frame.delete();
      idle_cnt = 0;
      e_addr = 0; e_data = 0; e_fun = 0;
    end else if (rx_valid) begin
      idle_cnt = 0;
      if (frame.size() == 0) begin
        if (is_cmd(rx_data)) frame.push_back(rx_data);
        else e_err = 1;
      end else begin
        frame.push_back(rx_data);
        pos  = frame.size() - 1;
        done = 0;
        case (frame[0])
          8'hAA: if (pos == 2) begin
            addr_byte = frame[1];
            e_wr = 1; e_addr = addr_byte[3:0]; e_data = rx_data; done = 1;
          end
          8'hBB: begin
            e_rd = 1; e_addr = rx_data[3:0]; done = 1;
          end
          8'hCC: begin
            if (pos == 1) begin e_wr = 1; e_addr = 4'd0; e_data = rx_data; end
            else if (pos == 2) begin e_wr = 1; e_addr = 4'd1; e_data = rx_data; end
            else begin e_alu = 1; e_fun = rx_data[3:0]; done = 1; end
          end
          default: begin
            e_alu = 1; e_fun = rx_data[3:0]; done = 1;
          end
        endcase
        if (done) frame.delete();
      end
    end else if (frame.size() != 0) begin
      idle_cnt++;
      if (idle_cnt == TIMEOUT) begin
        e_err = 1;
        frame.delete();
        idle_cnt = 0;
      end
    end
    e_busy = (frame.size() != 0);
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, frame_err, busy} !==
          {e_wr, e_rd, e_addr, e_data, e_alu, e_fun, e_err, e_busy}) begin
        n_fail++;
        $display("FAIL outputs t=%0t dut wr=%b rd=%b addr=%h data=%h alu=%b fun=%h err=%b busy=%b model wr=%b rd=%b addr=%h data=%h alu=%b fun=%h err=%b busy=%b",
                 $time, rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, frame_err, busy,
                 e_wr, e_rd, e_addr, e_data, e_alu, e_fun, e_err, e_busy);
      end
      n_cmp++;
      if ($countones({rf_wr_en, rf_rd_en, alu_en, frame_err}) > 1) begin
        n_fail++;
        $display("FAIL strobe_onehot t=%0t got %b%b%b%b need at most one high",
                 $time, rf_wr_en, rf_rd_en, alu_en, frame_err);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  logic [7:0] cmds[4];

  initial begin
    cmds[0] = 8'hAA; cmds[1] = 8'hBB; cmds[2] = 8'hCC; cmds[3] = 8'hDD;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_outputs", {rf_wr_en, rf_rd_en, alu_en, frame_err, busy, rf_addr, rf_wr_data, alu_fun}, 32'h0);

    // Register write
    send(8'hAA); send(8'h05); send(8'h3C);
    check("wr_strobe", {rf_wr_en, rf_rd_en, alu_en, frame_err}, 32'h8);
    check("wr_addr", rf_addr, 32'h5);
    check("wr_data", rf_wr_data, 32'h3C);
    tick();
    check("wr_after", {rf_wr_en, busy}, 32'h0);

    // Register read
    send(8'hBB); send(8'h0A);
    check("rd_strobe", {rf_wr_en, rf_rd_en, alu_en, frame_err}, 32'h4);
    check("rd_addr", rf_addr, 32'hA);

    // ALU with operands, then without
    send(8'hCC); send(8'h12);
    check("opa", {rf_wr_en, rf_addr, rf_wr_data}, {19'd0, 1'b1, 4'h0, 8'h12});
    send(8'h34);
    check("opb", {rf_wr_en, rf_addr, rf_wr_data}, {19'd0, 1'b1, 4'h1, 8'h34});
    send(8'h01);
    check("alu_op", {alu_en, rf_wr_en, alu_fun}, {26'd0, 1'b1, 1'b0, 4'h1});
    send(8'hDD); send(8'h02);
    check("alu_noop", {alu_en, alu_fun}, {27'd0, 1'b1, 4'h2});

    // Unknown command
    send(8'h55);
    check("bad_cmd", {frame_err, busy}, 32'h2);
    send(8'hAA); send(8'h01); send(8'hFF);
    check("wr_after_err", {rf_wr_en, rf_addr, rf_wr_data}, {19'd0, 1'b1, 4'h1, 8'hFF});

    // Timeout expiry
    send(8'hAA); send(8'h03);
    repeat (TIMEOUT - 1) tick();
    check("pre_expiry", {frame_err, busy}, 32'h1);
    tick();
    check("expiry", {frame_err, busy, rf_wr_en}, 32'h4);
    tick();
    check("expiry_once", frame_err, 32'h0);

    // Byte arriving on the expiry cycle wins
    send(8'hAA); send(8'h03);
    repeat (TIMEOUT - 1) tick();
    send(8'h77);
    check("late_byte", {frame_err, rf_wr_en, rf_addr, rf_wr_data}, {19'd0, 1'b0, 1'b1, 4'h3, 8'h77});

    // Reset mid-frame
    send(8'hCC); send(8'h11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_reset", {rf_wr_en, rf_rd_en, alu_en, frame_err, busy}, 32'h0);
    tick();
    check("post_reset", {rf_wr_en, rf_rd_en, alu_en, frame_err, busy}, 32'h0);
    send(8'hBB); send(8'h04);
    check("rd_after_reset", {rf_rd_en, rf_addr}, {27'd0, 1'b1, 4'h4});

    // Randomized traffic including held strobes, resets and long silences
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      rx_valid = ($urandom_range(0, 99) < 60);
      rx_data  = ($urandom_range(0, 1) == 0) ? cmds[$urandom_range(0, 3)] : 8'($urandom);
      tick();
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b0;
        rx_valid = 1'b0;
        repeat ($urandom_range(TIMEOUT - 15, TIMEOUT + 15)) tick();
      end
    end
    rst = 1'b0;
    rx_valid = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_cmd_decoder.md
RX_CMD_DECODER -- requirements
Module: rx_cmd_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, byte width of rx_data and rf_wr_data.
REQ-002 SHALL have parameter ADDR_W, default 4, register-file address width.
REQ-003 SHALL have parameter TIMEOUT, default 255, idle cycles allowed between bytes of one frame.
REQ-004 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rx_data  input  WIDTH  synchronized byte (sync_bus of upstream Data_Sync).
REQ-007 SHALL have port rx_valid  input  1  one-cycle byte strobe (en_pulse of upstream Data_Sync).
REQ-008 SHALL have port rf_wr_en  output  1  one-cycle register-file write strobe.
REQ-009 SHALL have port rf_rd_en  output  1  one-cycle register-file read strobe.
REQ-010 SHALL have port rf_addr  output  ADDR_W  register-file address.
REQ-011 SHALL have port rf_wr_data  output  WIDTH  register-file write data.
REQ-012 SHALL have port alu_en  output  1  one-cycle ALU start strobe.
REQ-013 SHALL have port alu_fun  output  4  ALU function code.
REQ-014 SHALL have port frame_err  output  1  one-cycle error strobe.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 Command bytes SHALL be: 0xAA reg-write (addr, data), 0xBB reg-read (addr), 0xCC ALU with operands (A, B, fun), 0xDD ALU without operands (fun).
REQ-017 FSM states SHALL be IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN; a byte is consumed only in a cycle with rx_valid=1.
REQ-018 IDLE: 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->OP_A, 0xDD->ALU_FUN; any other byte -> frame_err pulse, stay IDLE.
REQ-019 WR_ADDR: latch rx_data[ADDR_W-1:0] as address -> WR_DATA; WR_DATA: issue write of byte to latched address -> IDLE.
REQ-020 RD_ADDR: issue read at rx_data[ADDR_W-1:0] -> IDLE.
REQ-021 OP_A: issue write of byte to address 0 -> OP_B; OP_B: issue write to address 1 -> ALU_FUN.
REQ-022 ALU_FUN: drive alu_fun=rx_data[3:0], pulse alu_en -> IDLE.
REQ-023 All strobes SHALL be registered: asserted exactly one cycle, in the cycle after the rx_valid that triggered them; rf_addr/rf_wr_data/alu_fun valid in that same cycle and held until next update.
REQ-024 Timeout counter SHALL clear on every rx_valid and in IDLE, increment otherwise; on reaching TIMEOUT outside IDLE: frame_err pulse next cycle, state -> IDLE, no rf/alu strobe.
REQ-025 rx_valid and timeout in the same cycle: rx_valid wins, byte consumed, no error.
REQ-026 rx_valid held high N cycles SHALL be treated as N bytes.
REQ-027 At most one of rf_wr_en, rf_rd_en, alu_en, frame_err SHALL be high in any cycle.
REQ-028 busy SHALL be combinational from state (state != IDLE).

Reset
REQ-029 On rst=1 at a clock edge: state IDLE, counter 0, all strobes 0, rf_addr 0, rf_wr_data 0, alu_fun 0.
REQ-030 Reset mid-frame SHALL abandon the frame silently (no frame_err) and the next byte SHALL be decoded as a command.

Structure
REQ-031 Command codes, state encoding and ALU operand addresses (0, 1) SHALL live in shared package rx_cmd_pkg.
REQ-032 Timeout counter SHALL be sub-module frame_timer (ports clk, rst, clear, enable, expired); the rest stays flat.

Verification
REQ-033 Bytes AA,05,3C -> one cycle after third strobe: rf_wr_en=1, rf_addr=5, rf_wr_data=0x3C; busy low afterwards.
REQ-034 Bytes BB,0A -> rf_rd_en=1, rf_addr=0xA one cycle later; no other strobe.
REQ-035 Bytes CC,12,34,01 -> write addr0=0x12, write addr1=0x34, then alu_en=1 with alu_fun=1; DD,02 -> alu_en=1, alu_fun=2.
REQ-036 Byte 0x55 in IDLE -> frame_err pulse, busy stays 0; then AA,01,FF completes normally.
REQ-037 AA,03 then no rx_valid for 255 cycles -> frame_err once, state IDLE; a late byte 0x77 arriving exactly on the expiry cycle -> consumed as data, write addr3=0x77, no error.
REQ-038 CC,11 then rst high one cycle -> no strobes, busy 0; subsequent BB,04 -> rf_rd_en, rf_addr=4.
